inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 135 +++++++++++++
 tb/tb_inst_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Boot loader: assembles a big-endian byte stream into instruction words
// and writes them to instruction memory while holding the core in reset.
module inst_mem_loader #(
  parameter int SIZE_DATA = 32,
  parameter int ADD_SIZE  = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          n_words,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 wr_en,
  output logic [ADD_SIZE-1:0]  wr_addr,
  output logic [SIZE_DATA-1:0] wr_data,
  output logic                 core_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

  state_t         state_q;
  state_t         state_d;
  logic [15:0]    count_q;
  logic [15:0]    word_idx;
  logic [1:0]     byte_cnt;
  logic [31:0]    word_q;
  logic [ADD_SIZE-1:0]  wr_addr_q;
  logic [SIZE_DATA-1:0] wr_data_q;
  logic           error_q;
  logic           n_ok;
  logic           accept;
  logic           last_byte;
  logic           last_word;

  assign n_ok      = (n_words != 16'd0) &&
                     ({1'b0, n_words} <= MAX_WORDS);
  assign accept    = byte_valid && (state_q == RECV);
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign last_word = (word_idx == count_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start && n_ok) state_d = RECV;
      RECV: begin
        if (abort)          state_d = IDLE;
        else if (last_byte) state_d = WRITE;
      end
      WRITE: begin
        if (abort)          state_d = IDLE;
        else if (last_word) state_d = DONE;
        else                state_d = RECV;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == RECV);
    wr_en      = (state_q == WRITE);
    busy       = (state_q != IDLE);
    core_hold  = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  // Write port registers load on the 4th byte so they hold after WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      word_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && n_ok) begin
            count_q  <= n_words;
            word_idx <= '0;
            byte_cnt <= '0;
            word_q   <= '0;
            error_q  <= 1'b0;
          end else if (start) begin
            error_q  <= 1'b1;
          end
        end
        RECV: begin
          if (abort) begin
            error_q  <= 1'b1;
            byte_cnt <= '0;
            word_q   <= '0;
          end else if (accept) begin
            word_q   <= {word_q[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_data_q <= SIZE_DATA'({word_q[23:0], byte_in});
              wr_addr_q <= ADD_SIZE'({word_idx, 2'b00});
            end
          end
        end
        WRITE: begin
          if (abort)           error_q  <= 1'b1;
          else if (!last_word) word_idx <= word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign error   = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each wr_en strobe.
module tb_inst_mem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] n_words;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  inst_mem_loader #(
    .SIZE_DATA(32),
    .ADD_SIZE(32),
    .MEM_WORDS(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .n_words(n_words),
    .abort(abort),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   hold_drops = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h",
                 wr_addr, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        if (e.cyc >= 0) check("wr_cycle", cyc - t0 + 1, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d,
                          input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] n);
    start   = 1'b1;
    n_words = n;
    tick();
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc        = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = byte_ready;
      if (!core_hold) hold_drops++;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) tick();
      send_byte(w[31 - 8*i -: 8]);
    end
  endtask

  task automatic wait_done(output int k);
    logic found;
    found = 1'b0;
    k = -1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        k = cyc - t0 + 1;
      end
    end
    check("done_seen", found, 1);
  endtask

  initial begin
    int k;
    reset      = 1'b1;
    start      = 1'b0;
    n_words    = '0;
    abort      = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    #12;
    check("rst_flags",
          {byte_ready, wr_en, core_hold, busy, done, error}, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    #2 reset = 1'b0;
    tick();

    // single word, cycle-exact
    do_start(16'd1);
    push_exp(32'h0, 32'h2008_0005, 5);
    send_word(32'h2008_0005, 1'b0);
    wait_done(k);
    check("done_cycle_1w", k, 6);
    @(negedge clk);
    check("hold_released_1w", core_hold, 0);
    tick();

    // two words back to back, cycle-exact
    do_start(16'd2);
    push_exp(32'h0, 32'hDEAD_BEEF, 5);
    push_exp(32'h4, 32'h0123_4567, 10);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0123_4567, 1'b0);
    wait_done(k);
    check("done_cycle_2w", k, 11);
    @(negedge clk);
    check("hold_released_2w", {core_hold, busy}, 0);
    tick();

    // three words, byte_valid toggled
    hold_drops = 0;
    do_start(16'd3);
    push_exp(32'h0, 32'h1122_3344, -1);
    push_exp(32'h4, 32'h5566_7788, -1);
    push_exp(32'h8, 32'h99AA_BBCC, -1);
    send_word(32'h1122_3344, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    send_word(32'h99AA_BBCC, 1'b1);
    wait_done(k);
    check("hold_during_load", hold_drops, 0);
    tick();

    // rejected loads and error clearing
    do_start(16'd0);
    @(negedge clk);
    check("rej0_error", error, 1);
    check("rej0_idle", {busy, byte_ready}, 0);
    tick();
    do_start(16'd1);
    check("start_clears_err", {error, busy}, 2'b01);
    push_exp(32'h0, 32'hCAFE_F00D, -1);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_done(k);
    tick();
    do_start(16'd257);
    @(negedge clk);
    check("rej257_error", error, 1);
    check("rej257_idle", {busy, byte_ready}, 0);
    tick();
    do_start(16'd256);
    check("max_ok_clears_err", {error, busy}, 2'b01);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // abort after 2 bytes of word 1
    do_start(16'd2);
    push_exp(32'h0, 32'hA1A2_A3A4, -1);
    send_word(32'hA1A2_A3A4, 1'b0);
    send_byte(8'hB1);
    send_byte(8'hB2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_recv", {core_hold, byte_ready, error}, 3'b001);
    tick();

    // abort in WRITE still writes
    do_start(16'd2);
    push_exp(32'h0, 32'hC1C2_C3C4, -1);
    send_word(32'hC1C2_C3C4, 1'b0);
    check("in_write", wr_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_write", {busy, error}, 2'b01);
    tick();

    // async reset mid-RECV
    do_start(16'd2);
    push_exp(32'h0, 32'hD1D2_D3D4, -1);
    send_word(32'hD1D2_D3D4, 1'b0);
    send_byte(8'hE1);
    send_byte(8'hE2);
    #2 reset = 1'b1;
    #1;
    check("arst_flags",
          {byte_ready, wr_en, core_hold, busy, done, error}, 0);
    check("arst_addr", wr_addr, 0);
    check("arst_data", wr_data, 0);
    #2 reset = 1'b0;
    tick();
    do_start(16'd1);
    push_exp(32'h0, 32'h0F1E_2D3C, 5);
    send_word(32'h0F1E_2D3C, 1'b0);
    wait_done(k);
    check("done_cycle_post_rst", k, 6);
    tick();

    // start during RECV ignored
    do_start(16'd2);
    push_exp(32'h0, 32'h1357_9BDF, -1);
    push_exp(32'h4, 32'h2468_ACE0, -1);
    send_byte(8'h13);
    start   = 1'b1;
    n_words = 16'd5;
    send_byte(8'h57);
    start = 1'b0;
    send_byte(8'h9B);
    send_byte(8'hDF);
    send_word(32'h2468_ACE0, 1'b0);
    wait_done(k);
    @(negedge clk);
    check("orig_count_idle", busy, 0);
    tick();
    tick();

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
